io_bridge: RTL and testbench
============================

# io_bridge

Buffered I/O bridge between the external pins and the single-cycle CPU's 8-bit input and output ports. The receive side is a small FIFO with a valid/ready handshake. It presents its head byte to the CPU input port and pops on a CPU read strobe. The transmit side is a one-entry holding register with an IDLE/BUSY state machine. It captures the CPU output-port byte on a write strobe and hands it to the external consumer with a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4, receive FIFO entries; power of two, 2..16
- ADDR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately
- ext_in_data  in  8  byte offered by external producer
- ext_in_valid  in  1  producer has a byte
- ext_in_ready  out  1  FIFO can accept; equals !full
- cpu_in_data  out  8  FIFO head byte to CPU input port; 8'h00 when empty
- cpu_in_rd  in  1  CPU consumed head (input-port writeback cycle)
- cpu_out_data  in  8  CPU output-port byte
- cpu_out_we  in  1  CPU output-port write strobe
- ext_out_data  out  8  held transmit byte
- ext_out_valid  out  1  transmit byte pending
- ext_out_ready  in  1  external consumer accepts
- rx_count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
- err  out  2  sticky flags: [0] rx underflow, [1] tx overflow
- err_clr  in  1  clears err

## Operation
- Reset values: ext_in_ready=1, cpu_in_data=8'h00, ext_out_data=8'h00, ext_out_valid=0, rx_count=0, err=2'b00, TX state IDLE, read and write pointers 0.
- RX push: ext_in_valid && ext_in_ready at a clock edge writes mem[wptr]; wptr wraps modulo DEPTH.
- RX pop: cpu_in_rd && !empty advances rptr, which wraps modulo DEPTH. cpu_in_rd while empty is ignored and sets err[0].
- Simultaneous push and pop when neither full nor empty: both occur and rx_count is unchanged.
- Full: ext_in_ready=0, so a push is refused even when a pop happens in the same cycle. There is no bypass.
- Empty with a push: the byte appears on cpu_in_data the cycle after the push. There is no same-cycle pass-through.
- cpu_in_data = mem[rptr] when count>0, else 8'h00. This output is combinational from registered state.
- TX state machine:
  - IDLE: cpu_out_we captures cpu_out_data into ext_out_data and moves to BUSY.
  - BUSY: ext_out_valid=1 and ext_out_data is held stable.
  - BUSY, ext_out_ready=1 and cpu_out_we=0: return to IDLE.
  - BUSY, ext_out_ready=1 and cpu_out_we=1: capture the new byte and stay BUSY, giving back-to-back transfers with no bubble.
  - BUSY, ext_out_ready=0 and cpu_out_we=1: the new byte is dropped, the held byte is kept, and err[1] is set.
- err_clr clears err. An error event in the same cycle as err_clr wins, so the flag stays set.
- Reset asserted mid-transfer discards the FIFO contents and the pending TX byte. After release, outputs are at their reset values.

## Timing
- All state changes on the rising clk edge. The exception is rst, which acts asynchronously on assertion.
- RX latency: push at edge N; cpu_in_data is valid after edge N and rx_count increments at N.
- TX latency: cpu_out_we sampled at edge N; ext_out_valid=1 after edge N. ext_out_ready is sampled at edges only.
- ext_in_ready and ext_out_valid depend only on registered state. There are no combinational paths from input to output on the handshakes.
- Throughput: one RX byte per cycle and one TX byte per cycle when the consumer holds ready=1.

## Configuration
- Macro IO_BRIDGE_ERR_EN.
  - Defined: err flags and err_clr operate as described above.
  - Undefined: the error logic is not compiled. err is tied to 2'b00 and err_clr is ignored. Data and handshake behaviour is identical in both builds.

## Test plan
- Reset then idle: rst low mid-cycle → all outputs reset immediately, rx_count=0, cpu_in_data=8'h00.
- Fill and drain, DEPTH=4: push 8'h11, 8'h22, 8'h33, 8'h44 → ext_in_ready=0, rx_count=4, and a fifth push of 8'h55 is refused. Pop four times → cpu_in_data reads 11, 22, 33, 44, then 00.
- Wrap and simultaneous traffic: push 3 and pop 2, then push and pop together for 6 cycles with bytes 8'hA0..A5 → rx_count stays 1 and the output order is preserved across the pointer wrap.
- Underflow: cpu_in_rd while empty → err[0]=1 with IO_BRIDGE_ERR_EN, rx_count stays 0. err_clr → err=0. Without the macro → err=0 throughout.
- TX back-to-back: ext_out_ready=1, cpu_out_we on 3 consecutive cycles with 8'h01, 02, 03 → ext_out_data shows 01, 02, 03 on consecutive cycles with ext_out_valid continuously 1.
- TX stall overflow: ext_out_ready=0, write 8'h5A then 8'hC3 → ext_out_data stays 5A and err[1]=1. Raise ready → one transfer of 5A, then IDLE.

Source files
------------

// File: rtl/io_bridge.sv
// io_bridge: RX FIFO and one-entry TX holding register between pins and the CPU I/O ports.
// Optional sticky error flags are compiled in with IO_BRIDGE_ERR_EN.
module io_bridge #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        ext_in_data,
   input  logic              ext_in_valid,
   output logic              ext_in_ready,
   output logic [7:0]        cpu_in_data,
   input  logic              cpu_in_rd,
   input  logic [7:0]        cpu_out_data,
   input  logic              cpu_out_we,
   output logic [7:0]        ext_out_data,
   output logic              ext_out_valid,
   input  logic              ext_out_ready,
   output logic [ADDR_W:0]   rx_count,
   output logic [1:0]        err,
   input  logic              err_clr
);
   typedef enum logic {IDLE, BUSY} tx_state_t;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wptr, rptr;
   logic [ADDR_W:0]   count;
   tx_state_t         state;
   logic              full, empty, push, pop;
   assign full          = count == (ADDR_W+1)'(DEPTH);
   assign empty         = count == '0;
   assign push          = ext_in_valid && !full;
   assign pop           = cpu_in_rd && !empty;
   assign ext_in_ready  = !full;
   assign cpu_in_data   = empty ? 8'h00 : mem[rptr];
   assign rx_count      = count;
   assign ext_out_valid = state == BUSY;
   // Storage is not reset; an empty count already masks stale entries.
   always_ff @(posedge clk)
      if (push) mem[wptr] <= ext_in_data;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + ADDR_W'(1);
         if (pop) rptr <= rptr + ADDR_W'(1);
         count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      end
   // A write is taken when idle or when the held byte leaves on the same edge.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state        <= IDLE;
         ext_out_data <= 8'h00;
      end else if (cpu_out_we && (state == IDLE || ext_out_ready)) begin
         state        <= BUSY;
         ext_out_data <= cpu_out_data;
      end else if (ext_out_ready) begin
         state <= IDLE;
      end
`ifdef IO_BRIDGE_ERR_EN
   logic [1:0] err_q, err_set;
   assign err_set = {state == BUSY && !ext_out_ready && cpu_out_we, cpu_in_rd && empty};
   assign err     = err_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) err_q <= 2'b00;
      else err_q <= (err_clr ? 2'b00 : err_q) | err_set;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err            = 2'b00;
`endif
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed plus randomized checks of io_bridge against a queue-based model.
module tb_io_bridge;
   localparam int DEPTH = 4;
   localparam int ADDR_W = 2;
   logic clk = 0, rst = 0;
   logic [7:0] ext_in_data = 0, cpu_out_data = 0, cpu_in_data, ext_out_data;
   logic ext_in_valid = 0, cpu_in_rd = 0, cpu_out_we = 0, ext_out_ready = 0, err_clr = 0;
   logic ext_in_ready, ext_out_valid;
   logic [ADDR_W:0] rx_count;
   logic [1:0] err;
   int checks = 0, errors = 0;

   io_bridge #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid),
      .ext_in_ready(ext_in_ready), .cpu_in_data(cpu_in_data), .cpu_in_rd(cpu_in_rd),
      .cpu_out_data(cpu_out_data), .cpu_out_we(cpu_out_we), .ext_out_data(ext_out_data),
      .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready), .rx_count(rx_count),
      .err(err), .err_clr(err_clr));

   always #5 clk = ~clk;

`ifdef IO_BRIDGE_ERR_EN
   localparam bit ERR_ON = 1;
`else
   localparam bit ERR_ON = 0;
`endif

   // Reference model: the FIFO is a queue, TX is a pending flag plus byte.
   logic [7:0] q[$];
   logic       m_tv;
   logic [7:0] m_td;
   logic [1:0] m_err;
   always @(posedge clk or negedge rst)
      if (!rst) begin
         q.delete();
         m_tv = 0; m_td = 0; m_err = 0;
      end else begin
         logic [1:0] e;
         logic do_push;
         e = 0;
         do_push = ext_in_valid && q.size() < DEPTH;
         if (cpu_in_rd) begin
            if (q.size() > 0) void'(q.pop_front());
            else e[0] = 1;
         end
         if (do_push) q.push_back(ext_in_data);
         if (!m_tv) begin
            if (cpu_out_we) begin m_tv = 1; m_td = cpu_out_data; end
         end else if (ext_out_ready) begin
            if (cpu_out_we) m_td = cpu_out_data; else m_tv = 0;
         end else if (cpu_out_we) e[1] = 1;
         if (ERR_ON) m_err = (err_clr ? 2'b00 : m_err) | e;
      end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_rx_count", 32'(rx_count), 32'(q.size()));
      chk("m_ext_in_ready", 32'(ext_in_ready), 32'(q.size() < DEPTH));
      chk("m_cpu_in_data", 32'(cpu_in_data), q.size() > 0 ? 32'(q[0]) : 0);
      chk("m_ext_out_valid", 32'(ext_out_valid), 32'(m_tv));
      chk("m_ext_out_data", 32'(ext_out_data), 32'(m_td));
      chk("m_err", 32'(err), 32'(m_err));
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      ext_in_valid = 0; cpu_in_rd = 0; cpu_out_we = 0; err_clr = 0;
   endtask

   initial begin
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
      repeat (2) tick();
      rst = 1;
      tick();
      // Put some state in, then reset mid-cycle.
      ext_in_valid = 1; ext_in_data = 8'h77; cpu_out_we = 1; cpu_out_data = 8'h99;
      tick();
      idle();
      #2 rst = 0;
      #1;
      chk("rst_rx_count", 32'(rx_count), 0);
      chk("rst_cpu_in_data", 32'(cpu_in_data), 0);
      chk("rst_ext_in_ready", 32'(ext_in_ready), 1);
      chk("rst_ext_out_valid", 32'(ext_out_valid), 0);
      chk("rst_ext_out_data", 32'(ext_out_data), 0);
      chk("rst_err", 32'(err), 0);
      tick();
      rst = 1;
      tick();
      // Fill and drain.
      ext_in_valid = 1;
      for (int i = 0; i < 4; i++) begin ext_in_data = exp_b[i]; tick(); end
      ext_in_data = 8'h55; tick();
      ext_in_valid = 0;
      chk("full_count", 32'(rx_count), 4);
      chk("full_ready", 32'(ext_in_ready), 0);
      chk("full_head", 32'(cpu_in_data), 32'h11);
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", 32'(cpu_in_data), 32'(exp_b[i]));
         cpu_in_rd = 1; tick(); cpu_in_rd = 0;
      end
      chk("drain_empty_data", 32'(cpu_in_data), 0);
      chk("drain_empty_count", 32'(rx_count), 0);
      // Wrap with simultaneous traffic.
      ext_in_valid = 1;
      for (int i = 0; i < 3; i++) begin ext_in_data = 8'h31 + 8'(i); tick(); end
      ext_in_valid = 0; cpu_in_rd = 1;
      tick(); tick();
      chk("wrap_head", 32'(cpu_in_data), 32'h33);
      ext_in_valid = 1;
      for (int i = 0; i < 6; i++) begin
         ext_in_data = 8'hA0 + 8'(i); tick();
         chk("wrap_count", 32'(rx_count), 1);
         chk("wrap_data", 32'(cpu_in_data), 32'hA0 + 32'(i));
      end
      ext_in_valid = 0; tick(); cpu_in_rd = 0;
      // Underflow.
      cpu_in_rd = 1; tick(); cpu_in_rd = 0;
      chk("unf_err", 32'(err[0]), 32'(ERR_ON));
      chk("unf_count", 32'(rx_count), 0);
      err_clr = 1; tick(); err_clr = 0;
      chk("unf_clr", 32'(err), 0);
      // TX back-to-back.
      ext_out_ready = 1; cpu_out_we = 1;
      for (int i = 1; i <= 3; i++) begin
         cpu_out_data = 8'(i); tick();
         chk("b2b_valid", 32'(ext_out_valid), 1);
         chk("b2b_data", 32'(ext_out_data), 32'(i));
      end
      cpu_out_we = 0; tick();
      chk("b2b_idle", 32'(ext_out_valid), 0);
      // TX stall overflow.
      ext_out_ready = 0; cpu_out_we = 1; cpu_out_data = 8'h5A; tick();
      cpu_out_data = 8'hC3; tick();
      cpu_out_we = 0;
      chk("ovf_data", 32'(ext_out_data), 32'h5A);
      chk("ovf_valid", 32'(ext_out_valid), 1);
      chk("ovf_err", 32'(err[1]), 32'(ERR_ON));
      ext_out_ready = 1; tick();
      chk("ovf_done", 32'(ext_out_valid), 0);
      err_clr = 1; tick(); err_clr = 0;
      // Randomized traffic with occasional mid-cycle resets.
      for (int n = 0; n < 4000; n++) begin
         ext_in_valid = 1'($urandom_range(0, 2) != 0);
         ext_in_data = 8'($urandom);
         cpu_in_rd = 1'($urandom_range(0, 2) == 0);
         cpu_out_we = 1'($urandom_range(0, 1));
         cpu_out_data = 8'($urandom);
         ext_out_ready = 1'($urandom_range(0, 2) != 0);
         err_clr = 1'($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #3 rst = 0;
            tick();
            rst = 1;
         end else tick();
      end
      idle();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
